reg_serial_loader: RTL and testbench
====================================

Name: reg_serial_loader

Overview:
- Upstream stage for a bank of DEPTH enable-gated register cells, each WIDTH bits wide.
- Receives a serial write frame: address bits, then data bits, both MSB first.
- Drives a shared data bus and a one-hot per-register clock-enable, so exactly one register captures the assembled word on one clock edge.
- Reports frame completion and address or framing errors to the control logic.

Parameters:
- WIDTH, 8, data bits per register and width of d_bus.
- DEPTH, 8, number of registers in the downstream bank and width of clk_enable.
- ADDR_W, 3, address field length in bits. Must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  asynchronous, active-low reset.
- ser_start  input  1  frame start strobe; carries no data bit in its cycle.
- ser_valid  input  1  ser_bit is valid this cycle.
- ser_bit  input  1  serial data bit.
- err_clr  input  1  synchronous clear of the sticky err flag.
- busy  output  1  high while a frame is in progress, including the COMMIT cycle.
- d_bus  output  WIDTH  assembled data word presented to the register bank.
- clk_enable  output  DEPTH  one-hot write enable, bit i targets register i.
- done  output  1  one-cycle pulse on a successful write.
- err  output  1  sticky error flag.

Behaviour:
- Reset (clr low, asynchronous):
  - State goes to IDLE; bit counter 0; shift register 0.
  - d_bus=0, clk_enable=0, done=0, err=0, busy=0.
  - A frame in progress is discarded with no write.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, ADDR, DATA, COMMIT (plus PAR when PARITY_EN is defined).
- IDLE:
  - ser_valid is ignored.
  - ser_start=1 goes to ADDR and clears the bit counter and shift register.
- ADDR:
  - Each cycle with ser_valid=1 shifts ser_bit in, MSB first; ser_valid=0 cycles hold all state.
  - After ADDR_W bits, latch the address and go to DATA.
- DATA:
  - Same shifting rule for WIDTH bits.
  - After the last bit, go to COMMIT (or PAR).
- COMMIT (always exactly one cycle, then IDLE):
  - If address < DEPTH: clk_enable[address]=1 and done=1 for this cycle only; d_bus is loaded with the assembled word on entry to this cycle.
  - If address >= DEPTH: clk_enable stays 0, done=0, err is set, d_bus is unchanged.
- Latency: clk_enable is high in the cycle immediately after the cycle in which the last data bit was sampled.
- d_bus holds its value from one successful COMMIT until the next successful COMMIT or reset. It never changes in a cycle where clk_enable is nonzero except on COMMIT entry.
- clk_enable is all-zero outside COMMIT and has at most one bit set.
- ser_start while in ADDR, DATA or PAR:
  - Abort the current frame (no write) and set err.
  - Restart at ADDR with counters cleared.
- ser_start during COMMIT: the commit completes normally; the next cycle enters ADDR instead of IDLE.
- err_clr=1 clears err. If err_clr and a new error occur in the same cycle, err ends at 1 (set wins).

Optional Feature:
- Macro: REG_SERIAL_LOADER_PARITY_EN.
- Defined:
  - After DATA, state PAR samples one extra bit on the next ser_valid cycle (even parity over address and data bits).
  - On mismatch: go to IDLE with no write, no done, and set err.
  - On match: go to COMMIT. Write latency becomes one cycle after the parity bit is sampled.
- Undefined: no PAR state; DATA goes straight to COMMIT. Frame length is ADDR_W+WIDTH bits.

Test Plan:
- Basic write (WIDTH=8, DEPTH=8): start, then address 101, then data A5h, with no gaps.
  - Required: in the following cycle clk_enable=00100000, done=1, d_bus=A5h.
  - Next cycle: clk_enable=0, d_bus stays A5h, busy=0.
- Gapped input: same frame with ser_valid low on alternating cycles.
  - Required: identical result; enable appears one cycle after the last valid bit.
- Out-of-range address (DEPTH=6): address 111, data 3Ch.
  - Required: clk_enable stays 0, done stays 0, err=1, d_bus keeps its previous value.
  - Then err_clr=1 for one cycle: err returns to 0.
- Restart: ser_start after 4 data bits, then a full frame with address 010, data 0Fh.
  - Required: err=1; clk_enable=00000100; d_bus=0Fh. No write from the aborted frame.
- Reset mid-frame: clr low during DATA.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - After release, a full frame with address 001, data 81h writes normally.
- Parity (macro defined): frame with address 101, data A5h (six 1s), then parity bit 1.
  - Required: err=1 and no write.
  - Same frame with parity bit 0: clk_enable=00100000.

Source files
------------

// File: rtl/reg_serial_loader.sv
// Serial write-frame loader: shifts in address then data (MSB first) and drives a
// shared data bus plus a one-hot clock-enable. Optional parity bit: REG_SERIAL_LOADER_PARITY_EN.
module reg_serial_loader #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ser_start,
  input  logic             ser_valid,
  input  logic             ser_bit,
  input  logic             err_clr,
  output logic             busy,
  output logic [WIDTH-1:0] d_bus,
  output logic [DEPTH-1:0] clk_enable,
  output logic             done,
  output logic             err
);

  localparam int SH_W = (WIDTH > ADDR_W) ? WIDTH : ADDR_W;
  localparam int CW   = $clog2(SH_W + 1);
  localparam logic [CW-1:0]   ADDR_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0]   DATA_LAST = CW'(WIDTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
`ifdef REG_SERIAL_LOADER_PARITY_EN
    S_PAR,
`endif
    S_COMMIT
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [SH_W-1:0]     r_shift, w_shift_nxt, w_shifted;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [WIDTH-1:0]    w_word;
  logic [DEPTH-1:0]    w_onehot;
  logic                w_enter_commit, w_in_range, w_write, w_err_set;
`ifdef REG_SERIAL_LOADER_PARITY_EN
  logic                r_par, w_par_nxt;
`endif

  assign w_shifted  = SH_W'({r_shift, ser_bit});
  assign w_in_range = {1'b0, r_addr} < DEPTH_L;
  assign w_onehot   = DEPTH'(1) << r_addr;
  assign w_write    = w_enter_commit && w_in_range;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_addr_nxt     = r_addr;
    w_word         = w_shifted[WIDTH-1:0];
    w_enter_commit = 1'b0;
    w_err_set      = 1'b0;
`ifdef REG_SERIAL_LOADER_PARITY_EN
    w_par_nxt      = r_par;
`endif

    // Any start strobe begins a fresh frame with cleared counters.
    if (ser_start) begin
      w_state_nxt = S_ADDR;
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
`ifdef REG_SERIAL_LOADER_PARITY_EN
      w_par_nxt   = 1'b0;
`endif
    end

    case (r_state)
      S_IDLE: ;
      S_ADDR, S_DATA: begin
        if (ser_start) begin
          w_err_set = 1'b1;
        end else if (ser_valid) begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + CW'(1);
`ifdef REG_SERIAL_LOADER_PARITY_EN
          w_par_nxt   = r_par ^ ser_bit;
`endif
          if (r_state == S_ADDR && r_cnt == ADDR_LAST) begin
            w_addr_nxt  = w_shifted[ADDR_W-1:0];
            w_cnt_nxt   = '0;
            w_state_nxt = S_DATA;
          end else if (r_state == S_DATA && r_cnt == DATA_LAST) begin
            w_cnt_nxt   = '0;
`ifdef REG_SERIAL_LOADER_PARITY_EN
            w_state_nxt = S_PAR;
`else
            w_state_nxt    = S_COMMIT;
            w_enter_commit = 1'b1;
`endif
          end
        end
      end
`ifdef REG_SERIAL_LOADER_PARITY_EN
      S_PAR: begin
        if (ser_start) begin
          w_err_set = 1'b1;
        end else if (ser_valid) begin
          w_word = r_shift[WIDTH-1:0];
          if (ser_bit == r_par) begin
            w_state_nxt    = S_COMMIT;
            w_enter_commit = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_err_set   = 1'b1;
          end
        end
      end
`endif
      S_COMMIT: begin
        if (!ser_start) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_enter_commit && !w_in_range) w_err_set = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_addr     <= '0;
      d_bus      <= '0;
      clk_enable <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
`ifdef REG_SERIAL_LOADER_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_addr     <= w_addr_nxt;
      clk_enable <= w_write ? w_onehot : '0;
      done       <= w_write;
      busy       <= (w_state_nxt != S_IDLE);
      if (w_write) d_bus <= w_word;
      // A new error wins over a simultaneous clear.
      if (w_err_set)    err <= 1'b1;
      else if (err_clr) err <= 1'b0;
`ifdef REG_SERIAL_LOADER_PARITY_EN
      r_par      <= w_par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_reg_serial_loader.sv
// Directed bench for reg_serial_loader: one DEPTH=8 and one DEPTH=6 instance share stimulus.
module tb_reg_serial_loader;

  logic clk = 1'b0;
  logic clr, ser_start, ser_valid, ser_bit, err_clr;

  logic       busy8, done8, err8;
  logic [7:0] d_bus8, en8;
  logic       busy6, done6, err6;
  logic [7:0] d_bus6;
  logic [5:0] en6;

  int checks = 0;
  int errors = 0;

  reg_serial_loader #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) u_dut8 (
    .clk(clk), .clr(clr), .ser_start(ser_start), .ser_valid(ser_valid),
    .ser_bit(ser_bit), .err_clr(err_clr), .busy(busy8), .d_bus(d_bus8),
    .clk_enable(en8), .done(done8), .err(err8)
  );

  reg_serial_loader #(.WIDTH(8), .DEPTH(6), .ADDR_W(3)) u_dut6 (
    .clk(clk), .clr(clr), .ser_start(ser_start), .ser_valid(ser_valid),
    .ser_bit(ser_bit), .err_clr(err_clr), .busy(busy6), .d_bus(d_bus6),
    .clk_enable(en6), .done(done6), .err(err6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    ser_start = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic start_frame();
    @(negedge clk);
    ser_start = 1'b1;
    ser_valid = 1'b0;
    err_clr   = 1'b0;
  endtask

  task automatic send_bit(input logic b, input bit gap);
    @(negedge clk);
    ser_start = 1'b0;
    ser_valid = 1'b1;
    ser_bit   = b;
    if (gap) begin
      @(negedge clk);
      ser_valid = 1'b0;
      ser_bit   = ~b;
    end
  endtask

  task automatic send_frame_raw(input logic [2:0] addr, input logic [7:0] data, input bit gap);
    for (int i = 2; i >= 0; i--) send_bit(addr[i], gap);
    for (int i = 7; i >= 0; i--) send_bit(data[i], gap && (i != 0));
  endtask

  task automatic send_frame(input logic [2:0] addr, input logic [7:0] data, input bit gap);
    start_frame();
    send_frame_raw(addr, data, gap);
`ifdef REG_SERIAL_LOADER_PARITY_EN
    send_bit(^{addr, data}, 1'b0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clr = 1'b1; ser_start = 1'b0; ser_valid = 1'b0; ser_bit = 1'b0; err_clr = 1'b0;
    #2 clr = 1'b0;
    #1;
    check("rst_d_bus", d_bus8, 0);
    check("rst_en",    en8,    0);
    check("rst_done",  done8,  0);
    check("rst_err",   err8,   0);
    check("rst_busy",  busy8,  0);
    @(negedge clk);
    clr = 1'b1;

    // Basic write: addr 101, data A5
    send_frame(3'b101, 8'hA5, 1'b0);
    idle_cycle();
    check("basic_en",    en8,    8'b0010_0000);
    check("basic_done",  done8,  1);
    check("basic_d_bus", d_bus8, 8'hA5);
    check("basic_busy",  busy8,  1);
    check("basic_en6",   en6,    6'b10_0000);
    idle_cycle();
    check("basic_en_off",  en8,    0);
    check("basic_done_off", done8, 0);
    check("basic_d_hold",  d_bus8, 8'hA5);
    check("basic_busy_off", busy8, 0);

    // Gapped input
    send_frame(3'b101, 8'hA5, 1'b1);
    check("gap_en_early", en8, 0);
    check("gap_busy_mid", busy8, 1);
    idle_cycle();
    check("gap_en",    en8,    8'b0010_0000);
    check("gap_done",  done8,  1);
    check("gap_d_bus", d_bus8, 8'hA5);
    idle_cycle();

    // Out-of-range address on DEPTH=6; in range on DEPTH=8
    send_frame(3'b111, 8'h3C, 1'b0);
    idle_cycle();
    check("oor_en6",   en6,    0);
    check("oor_done6", done6,  0);
    check("oor_err6",  err6,   1);
    check("oor_d6",    d_bus6, 8'hA5);
    check("oor_en8",   en8,    8'b1000_0000);
    check("oor_d8",    d_bus8, 8'h3C);
    check("oor_err8",  err8,   0);
    idle_cycle();
    check("oor_err6_sticky", err6, 1);
    err_clr = 1'b1;
    idle_cycle();
    check("errclr_err6", err6, 0);

    // Restart after 4 data bits, then full frame addr 010 data 0F
    start_frame();
    for (int i = 2; i >= 0; i--) send_bit(i == 1, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    start_frame();
    idle_cycle();
    check("rst_abort_err",  err8,  1);
    check("rst_abort_en",   en8,   0);
    check("rst_abort_done", done8, 0);
    send_frame_raw(3'b010, 8'h0F, 1'b0);
`ifdef REG_SERIAL_LOADER_PARITY_EN
    send_bit(^{3'b010, 8'h0F}, 1'b0);
`endif
    idle_cycle();
    check("restart_en",   en8,    8'b0000_0100);
    check("restart_d",    d_bus8, 8'h0F);
    check("restart_err",  err8,   1);
    check("restart_done", done8,  1);

    // Asynchronous reset mid-frame
    start_frame();
    for (int i = 2; i >= 0; i--) send_bit(i == 0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    @(negedge clk);
    ser_valid = 1'b0;
    clr = 1'b0;
    #1;
    check("arst_d_bus", d_bus8, 0);
    check("arst_en",    en8,    0);
    check("arst_done",  done8,  0);
    check("arst_err",   err8,   0);
    check("arst_busy",  busy8,  0);
    @(negedge clk);
    clr = 1'b1;
    send_frame(3'b001, 8'h81, 1'b0);
    idle_cycle();
    check("post_rst_en", en8,    8'b0000_0010);
    check("post_rst_d",  d_bus8, 8'h81);
    idle_cycle();

`ifdef REG_SERIAL_LOADER_PARITY_EN
    start_frame();
    send_frame_raw(3'b101, 8'hA5, 1'b0);
    send_bit(1'b1, 1'b0);
    idle_cycle();
    check("par_bad_en",   en8,   0);
    check("par_bad_done", done8, 0);
    check("par_bad_err",  err8,  1);
    check("par_bad_d",    d_bus8, 8'h81);
    idle_cycle();
    start_frame();
    send_frame_raw(3'b101, 8'hA5, 1'b0);
    send_bit(1'b0, 1'b0);
    idle_cycle();
    check("par_ok_en", en8,    8'b0010_0000);
    check("par_ok_d",  d_bus8, 8'hA5);
    idle_cycle();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
